// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants (standard porch/sync sets) and helpers for the raster
// timing generator, its divider and any renderer that needs mode geometry.
package vga_timing_gen_pkg;

   typedef struct packed {
      int unsigned disp;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } vgaAxis_t;

   localparam vgaAxis_t MODE640_H = '{disp: 640, fp: 16, sync: 96,  bp: 48};
   localparam vgaAxis_t MODE640_V = '{disp: 480, fp: 10, sync: 2,   bp: 33};
   localparam vgaAxis_t MODE800_H = '{disp: 800, fp: 40, sync: 128, bp: 88};
   localparam vgaAxis_t MODE800_V = '{disp: 600, fp: 1,  sync: 4,   bp: 23};

   function automatic int unsigned axisTotal(input int unsigned disp, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
      return disp + fp + sync + bp;
   endfunction

   // A divide-by-one still needs a 1-bit counter so the divider stays a legal register.
   function automatic int unsigned divWidth(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus between vga_timing_gen (master) and pixel/sprite renderers (slave).
// nx_x/nx_y exist only when VGA_TIMING_LOOKAHEAD_EN is defined.
interface vga_timing_gen_if #(parameter int unsigned CW = 10);

   logic          en;
   logic          p_tick;
   logic [CW-1:0] pixel_x;
   logic [CW-1:0] pixel_y;
   logic          hsync;
   logic          vsync;
   logic          video_on;
   logic          line_start;
   logic          frame_start;

`ifdef VGA_TIMING_LOOKAHEAD_EN
   logic [CW-1:0] nx_x;
   logic [CW-1:0] nx_y;

   modport master (input en, output p_tick, pixel_x, pixel_y, hsync, vsync, video_on,
                   line_start, frame_start, nx_x, nx_y);
   modport slave  (output en, input p_tick, pixel_x, pixel_y, hsync, vsync, video_on,
                   line_start, frame_start, nx_x, nx_y);
`else
   modport master (input en, output p_tick, pixel_x, pixel_y, hsync, vsync, video_on,
                   line_start, frame_start);
   modport slave  (output en, input p_tick, pixel_x, pixel_y, hsync, vsync, video_on,
                   line_start, frame_start);
`endif

endinterface

// File: rtl/vga_timing_gen_pix_div.sv
// Pixel-rate divider: p_tick is a one-clk enable every PIX_DIV clks while en is high.
module vga_pix_div
   import vga_timing_gen_pkg::*;
#(
   parameter int unsigned PIX_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic p_tick
);

   localparam int unsigned   DW   = divWidth(PIX_DIV);
   localparam logic [DW-1:0] LAST = DW'(PIX_DIV - 1);

   logic [DW-1:0] div_q;
   logic [DW-1:0] div_d;
   logic          atLast;

   assign atLast = (div_q == LAST);

   always_comb begin
      div_d = div_q;
      if (en) begin
         div_d = atLast ? '0 : div_q + DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         div_q <= '0;
      end else begin
         div_d_apply: div_q <= div_d;
      end
   end

   // Gated by reset so the counters never see a tick in the same clk reset is applied.
   assign p_tick = reset & en & atLast;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA raster timing generator: h/v counters, registered sync/blank, strobes.
// Define VGA_TIMING_LOOKAHEAD_EN to add the registered next-pixel coordinates nx_x/nx_y.
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int unsigned CW      = 10,
   parameter int unsigned H_DISP  = MODE640_H.disp,
   parameter int unsigned H_FP    = MODE640_H.fp,
   parameter int unsigned H_SYNC  = MODE640_H.sync,
   parameter int unsigned H_BP    = MODE640_H.bp,
   parameter int unsigned V_DISP  = MODE640_V.disp,
   parameter int unsigned V_FP    = MODE640_V.fp,
   parameter int unsigned V_SYNC  = MODE640_V.sync,
   parameter int unsigned V_BP    = MODE640_V.bp,
   parameter int unsigned PIX_DIV = 2,
   parameter bit          HS_POL  = 1'b0,
   parameter bit          VS_POL  = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   vga_timing_gen_if.master  vga
);

   localparam int unsigned   H_TOTAL  = axisTotal(H_DISP, H_FP, H_SYNC, H_BP);
   localparam int unsigned   V_TOTAL  = axisTotal(V_DISP, V_FP, V_SYNC, V_BP);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS    = CW'(H_DISP);
   localparam logic [CW-1:0] V_VIS    = CW'(V_DISP);
   localparam logic [CW-1:0] HS_FIRST = CW'(H_DISP + H_FP);
   localparam logic [CW-1:0] HS_LAST  = CW'(H_DISP + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_FIRST = CW'(V_DISP + V_FP);
   localparam logic [CW-1:0] VS_LAST  = CW'(V_DISP + V_FP + V_SYNC - 1);

   if (H_TOTAL >= (32'd1 << CW)) begin : gBadHTotal
      $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
   end
   if (V_TOTAL >= (32'd1 << CW)) begin : gBadVTotal
      $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
   end
   if (PIX_DIV < 1) begin : gBadPixDiv
      $error("vga_timing_gen: PIX_DIV must be at least 1");
   end

   logic          pTick;
   logic [CW-1:0] xCount_q, xCount_d;
   logic [CW-1:0] yCount_q, yCount_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          videoOn_q, videoOn_d;
   logic          lineStart_q, lineStart_d;
   logic          frameStart_q, frameStart_d;

   vga_pix_div #(.PIX_DIV(PIX_DIV)) uPixDiv (
      .clk    (clk),
      .reset  (reset),
      .en     (vga.en),
      .p_tick (pTick)
   );

   // Decode from the next coordinate so sync/blank land in the same clk as the new x/y.
   always_comb begin
      xCount_d = xCount_q + 1'b1;
      yCount_d = yCount_q;
      if (xCount_q == H_LAST) begin
         xCount_d = '0;
         yCount_d = (yCount_q == V_LAST) ? '0 : yCount_q + 1'b1;
      end
      hsync_d      = ((xCount_d >= HS_FIRST) && (xCount_d <= HS_LAST)) ? HS_POL : ~HS_POL;
      vsync_d      = ((yCount_d >= VS_FIRST) && (yCount_d <= VS_LAST)) ? VS_POL : ~VS_POL;
      videoOn_d    = (xCount_d < H_VIS) && (yCount_d < V_VIS);
      lineStart_d  = (xCount_d == '0);
      frameStart_d = lineStart_d && (yCount_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         xCount_q     <= '0;
         yCount_q     <= '0;
         hsync_q      <= ~HS_POL;
         vsync_q      <= ~VS_POL;
         videoOn_q    <= 1'b0;
         lineStart_q  <= 1'b0;
         frameStart_q <= 1'b0;
      end else begin
         lineStart_q  <= 1'b0;
         frameStart_q <= 1'b0;
         if (pTick) begin
            xCount_q     <= xCount_d;
            yCount_q     <= yCount_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            videoOn_q    <= videoOn_d;
            lineStart_q  <= lineStart_d;
            frameStart_q <= frameStart_d;
         end
      end
   end

   assign vga.p_tick      = pTick;
   assign vga.pixel_x     = xCount_q;
   assign vga.pixel_y     = yCount_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.video_on    = videoOn_q;
   assign vga.line_start  = lineStart_q;
   assign vga.frame_start = frameStart_q;

`ifdef VGA_TIMING_LOOKAHEAD_EN
   logic [CW-1:0] nxX_q, nxX_d;
   logic [CW-1:0] nxY_q, nxY_d;

   // One step beyond the coordinate being loaded, so nx always leads pixel_x/y by one tick.
   always_comb begin
      nxX_d = xCount_d + 1'b1;
      nxY_d = yCount_d;
      if (xCount_d == H_LAST) begin
         nxX_d = '0;
         nxY_d = (yCount_d == V_LAST) ? '0 : yCount_d + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         nxX_q <= CW'(1);
         nxY_q <= '0;
      end else if (pTick) begin
         nxX_q <= nxX_d;
         nxY_q <= nxY_d;
      end
   end

   assign vga.nx_x = nxX_q;
   assign vga.nx_y = nxY_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on two reduced geometries (PIX_DIV=2 active-low, PIX_DIV=1 active-high).
module tb_vga_timing_gen;

   typedef struct {
      int x;
      int y;
      int nx;
      int ny;
      bit hs;
      bit vs;
      bit von;
      bit ls;
      bit fs;
   } expRec_t;

   logic clk = 1'b0;
   logic resetA;
   logic resetB;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   expRec_t qA[$];
   expRec_t qB[$];
   int  nA = 0, nB = 0;
   bit  pendA = 1'b0, pendB = 1'b0;
   int  vonA = 0, hsA = 0, vsA = 0, lsA = 0, fsA = 0;
   int  vonB = 0, hsB = 0, vsB = 0, lsB = 0, fsB = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vga_timing_gen_if #(.CW(10)) busA ();
   vga_timing_gen_if #(.CW(10)) busB ();

   // A: 24x13 raster, hsync x=18..20, vsync y=9..10, active-low, 2 clks per pixel.
   vga_timing_gen #(
      .CW(10), .H_DISP(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_DISP(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .PIX_DIV(2), .HS_POL(1'b0), .VS_POL(1'b0)
   ) dutA (
      .clk   (clk),
      .reset (resetA),
      .vga   (busA)
   );

   // B: 16x9 raster, hsync x=11..13, vsync y=6..7, active-high, 1 clk per pixel.
   vga_timing_gen #(
      .CW(10), .H_DISP(10), .H_FP(1), .H_SYNC(3), .H_BP(2),
      .V_DISP(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .PIX_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1)
   ) dutB (
      .clk   (clk),
      .reset (resetB),
      .vga   (busB)
   );

   function automatic expRec_t model(input int n, input int ht, input int vt, input int hd,
                                     input int vd, input int hss, input int hse, input int vss,
                                     input int vse, input bit hpol, input bit vpol);
      expRec_t r;
      int p, np;
      p     = n % (ht * vt);
      np    = (n + 1) % (ht * vt);
      r.x   = p % ht;
      r.y   = p / ht;
      r.nx  = np % ht;
      r.ny  = np / ht;
      r.hs  = (r.x >= hss && r.x <= hse) ? hpol : !hpol;
      r.vs  = (r.y >= vss && r.y <= vse) ? vpol : !vpol;
      r.von = (r.x < hd) && (r.y < vd);
      r.ls  = (r.x == 0);
      r.fs  = (p == 0);
      return r;
   endfunction

   function automatic expRec_t modelA(input int n);
      return model(n, 24, 13, 16, 8, 18, 20, 9, 10, 1'b0, 1'b0);
   endfunction

   function automatic expRec_t modelB(input int n);
      return model(n, 16, 9, 10, 5, 11, 13, 6, 7, 1'b1, 1'b1);
   endfunction

   function automatic expRec_t mkRec(input int x, input int y, input bit hs, input bit vs,
                                     input bit von, input bit ls, input bit fs);
      expRec_t r;
      r.x = x; r.y = y; r.nx = 0; r.ny = 0;
      r.hs = hs; r.vs = vs; r.von = von; r.ls = ls; r.fs = fs;
      return r;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic compareRec(input string tag, input expRec_t e, input int x, input int y,
                             input bit hs, input bit vs, input bit von, input bit ls, input bit fs);
      checkOutput({tag, " pixel_x"}, x, e.x);
      checkOutput({tag, " pixel_y"}, y, e.y);
      checkOutput({tag, " hsync"}, int'(hs), int'(e.hs));
      checkOutput({tag, " vsync"}, int'(vs), int'(e.vs));
      checkOutput({tag, " video_on"}, int'(von), int'(e.von));
      checkOutput({tag, " line_start"}, int'(ls), int'(e.ls));
      checkOutput({tag, " frame_start"}, int'(fs), int'(e.fs));
   endtask

   // Monitor A: one clk after each p_tick the updated state must match the queued expectation.
   always @(negedge clk) begin : monA
      expRec_t e;
      if (pendA) begin
         if (qA.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL A unexpected p_tick: actual=tick required=none");
         end else begin
            e = qA.pop_front();
            compareRec("A", e, int'(busA.pixel_x), int'(busA.pixel_y), busA.hsync, busA.vsync,
                       busA.video_on, busA.line_start, busA.frame_start);
`ifdef VGA_TIMING_LOOKAHEAD_EN
            checkOutput("A nx_x", int'(busA.nx_x), e.nx);
            checkOutput("A nx_y", int'(busA.nx_y), e.ny);
`endif
         end
         if (busA.video_on) vonA++;
         if (!busA.hsync) hsA++;
         if (!busA.vsync) vsA++;
      end
      if (busA.line_start) lsA++;
      if (busA.frame_start) fsA++;
      pendA = busA.p_tick;
   end

   always @(negedge clk) begin : monB
      expRec_t e;
      if (pendB) begin
         if (qB.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL B unexpected p_tick: actual=tick required=none");
         end else begin
            e = qB.pop_front();
            compareRec("B", e, int'(busB.pixel_x), int'(busB.pixel_y), busB.hsync, busB.vsync,
                       busB.video_on, busB.line_start, busB.frame_start);
`ifdef VGA_TIMING_LOOKAHEAD_EN
            checkOutput("B nx_x", int'(busB.nx_x), e.nx);
            checkOutput("B nx_y", int'(busB.nx_y), e.ny);
`endif
         end
         if (busB.video_on) vonB++;
         if (busB.hsync) hsB++;
         if (busB.vsync) vsB++;
      end
      if (busB.line_start) lsB++;
      if (busB.frame_start) fsB++;
      pendB = busB.p_tick;
   end

   // Queue the expected state for each upcoming tick, then wait (bounded) for the DUT to tick.
   task automatic applyStimulus(input bit useB, input int count);
      for (int i = 0; i < count; i++) begin
         int waitClks;
         waitClks = 0;
         if (useB) begin
            nB++;
            qB.push_back(modelB(nB));
         end else begin
            nA++;
            qA.push_back(modelA(nA));
         end
         @(negedge clk);
         while (!(useB ? busB.p_tick : busA.p_tick) && waitClks < 20) begin
            @(negedge clk);
            waitClks++;
         end
         if (!(useB ? busB.p_tick : busA.p_tick)) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s tick timeout: actual=no p_tick in 20 clks required=p_tick",
                     useB ? "B" : "A");
         end
      end
   endtask

   task automatic advanceA(input int tx, input int ty);
      int cur, tgt;
      cur = nA % 312;
      tgt = ty * 24 + tx;
      applyStimulus(1'b0, (tgt - cur + 312) % 312);
   endtask

   task automatic checkResetA(input string tag);
      compareRec(tag, mkRec(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), int'(busA.pixel_x),
                 int'(busA.pixel_y), busA.hsync, busA.vsync, busA.video_on,
                 busA.line_start, busA.frame_start);
      checkOutput({tag, " p_tick"}, int'(busA.p_tick), 0);
`ifdef VGA_TIMING_LOOKAHEAD_EN
      checkOutput({tag, " nx_x"}, int'(busA.nx_x), 1);
      checkOutput({tag, " nx_y"}, int'(busA.nx_y), 0);
`endif
   endtask

   initial begin : stim
      int c0;
      resetA  = 1'b0;
      resetB  = 1'b0;
      busA.en = 1'b1;
      busB.en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetA("A reset");
      compareRec("B reset", mkRec(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), int'(busB.pixel_x),
                 int'(busB.pixel_y), busB.hsync, busB.vsync, busB.video_on,
                 busB.line_start, busB.frame_start);
      checkOutput("B reset p_tick", int'(busB.p_tick), 0);

      // A: two full frames; tick k is observed 2k-1 posedges after release.
      @(posedge clk);
      #1 resetA = 1'b1;
      c0 = cyc;
      vonA = 0; hsA = 0; vsA = 0; lsA = 0; fsA = 0;
      applyStimulus(1'b0, 624);
      checkOutput("A clks for 624 ticks", cyc - c0, 1247);
      @(posedge clk);
      #1 busA.en = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("A video_on ticks 2 frames", vonA, 256);
      checkOutput("A hsync active ticks 2 frames", hsA, 78);
      checkOutput("A vsync active ticks 2 frames", vsA, 96);
      checkOutput("A line_start pulses 2 frames", lsA, 26);
      checkOutput("A frame_start pulses 2 frames", fsA, 2);
      busA.en = 1'b1;

      // A: freeze at x=10,y=3 for 37 clks, then resume with x=11.
      advanceA(10, 3);
      @(posedge clk);
      #1 busA.en = 1'b0;
      repeat (37) @(posedge clk);
      @(negedge clk);
      compareRec("A frozen", mkRec(10, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), int'(busA.pixel_x),
                 int'(busA.pixel_y), busA.hsync, busA.vsync, busA.video_on,
                 busA.line_start, busA.frame_start);
      @(posedge clk);
      #1 busA.en = 1'b1;
      applyStimulus(1'b0, 1);

      // A: one-clk reset at x=19,y=10 while both syncs are active.
      advanceA(19, 10);
      @(posedge clk);
      #1 resetA = 1'b0;
      @(negedge clk);
      compareRec("A pre-reset", mkRec(19, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), int'(busA.pixel_x),
                 int'(busA.pixel_y), busA.hsync, busA.vsync, busA.video_on,
                 busA.line_start, busA.frame_start);
      @(posedge clk);
      #1 resetA = 1'b1;
      nA  = 0;
      lsA = 0;
      fsA = 0;
      @(negedge clk);
      checkResetA("A mid-frame reset");
      applyStimulus(1'b0, 312);
      @(posedge clk);
      #1 busA.en = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("A frame_start in frame after reset", fsA, 1);

      // B: two full frames at one pixel per clk, tick k observed k-1 posedges after release.
      @(posedge clk);
      #1 resetB = 1'b1;
      c0 = cyc;
      vonB = 0; hsB = 0; vsB = 0; lsB = 0; fsB = 0;
      applyStimulus(1'b1, 288);
      checkOutput("B clks for 288 ticks", cyc - c0, 287);
      @(posedge clk);
      #1 busB.en = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("B video_on ticks 2 frames", vonB, 100);
      checkOutput("B hsync active ticks 2 frames", hsB, 54);
      checkOutput("B vsync active ticks 2 frames", vsB, 64);
      checkOutput("B line_start pulses 2 frames", lsB, 18);
      checkOutput("B frame_start pulses 2 frames", fsB, 2);

      repeat (4) @(negedge clk);
      checkOutput("A queue drained", qA.size(), 0);
      checkOutput("B queue drained", qB.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: actual=still running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
